rr_arbiter_8: RTL and testbench

- Round-robin arbiter that shares one downstream resource among 8 requesters.
- Uses an 8-to-3 priority encode as its selection core, with a rotating mask for fairness.
- A grant is held until the owner releases it or a hold-timeout forces rotation.
- Sits in front of any shared datapath unit (bus, ALU, memory port) that needs one-at-a-time access.

---
 rtl/rr_arb_pkg.sv | 20 ++
 rtl/rr_arbiter_8_prio_enc8.sv | 21 ++
 rtl/rr_arbiter_8.sv | 137 +++++++++++++
 tb/tb_rr_arbiter_8.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 8-requester round-robin arbiter.
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Turns a binary requester index into a one-hot grant vector.
    function automatic logic [N_REQ-1:0] one_hot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_prio_enc8.sv
// Combinational 8-to-3 priority encoder; the highest set bit wins.
module prio_enc8
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] in_vec,
    output logic [ID_W-1:0]  id,
    output logic             valid
);

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        id    = '0;
        valid = |in_vec;
        for (int i = 0; i < N_REQ; i++) begin
            if (in_vec[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with grant hold and hold-timeout.
module rr_arbiter_8
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int HC_RAW = $clog2(MAX_HOLD + 1);
    localparam int HC_W   = (HC_RAW < 1) ? 1 : HC_RAW;

    arb_state_t       state, state_n;
    logic [ID_W-1:0]  last_id, last_id_n;
    logic [HC_W-1:0]  hold_cnt, hold_cnt_n;
    logic [N_REQ-1:0] gnt_n;
    logic [ID_W-1:0]  gnt_id_n;
    logic             gnt_valid_n;
    logic             timeout_n;

    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] masked;
    logic [ID_W-1:0]  m_id, u_id;
    logic             m_valid, u_valid;
    logic [ID_W-1:0]  winner;
    logic             win_valid;
    logic             owner_req;
    logic             hold_full;

    // Candidates exclude the current owner: in IDLE gnt is zero, on release the
    // owner bit is already low, and on timeout the owner must be skipped anyway.
    always_comb begin
        cand   = req & ~gnt;
        mask   = one_hot(last_id) - N_REQ'(1);
        masked = cand & mask;
    end

    prio_enc8 u_enc_masked (
        .in_vec (masked),
        .id     (m_id),
        .valid  (m_valid)
    );

    prio_enc8 u_enc_full (
        .in_vec (cand),
        .id     (u_id),
        .valid  (u_valid)
    );

    // Prefer requesters below the last owner, otherwise wrap to the top.
    always_comb begin
        winner    = m_valid ? m_id : u_id;
        win_valid = u_valid;
        owner_req = req[gnt_id];
        hold_full = (MAX_HOLD != 0) && (hold_cnt == HC_W'(MAX_HOLD));
    end

    // Next-state and next-output decisions for the grant FSM.
    always_comb begin
        state_n     = state;
        last_id_n   = last_id;
        hold_cnt_n  = hold_cnt;
        gnt_n       = gnt;
        gnt_id_n    = gnt_id;
        gnt_valid_n = gnt_valid;
        timeout_n   = 1'b0;

        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_n     = BUSY;
                    gnt_n       = one_hot(winner);
                    gnt_id_n    = winner;
                    gnt_valid_n = 1'b1;
                    last_id_n   = winner;
                    hold_cnt_n  = HC_W'(1);
                end
            end
            BUSY: begin
                if (!owner_req) begin
                    if (win_valid) begin
                        gnt_n       = one_hot(winner);
                        gnt_id_n    = winner;
                        last_id_n   = winner;
                        hold_cnt_n  = HC_W'(1);
                    end else begin
                        state_n     = IDLE;
                        gnt_n       = '0;
                        gnt_valid_n = 1'b0;
                    end
                end else if (hold_full && win_valid) begin
                    gnt_n      = one_hot(winner);
                    gnt_id_n   = winner;
                    last_id_n  = winner;
                    hold_cnt_n = HC_W'(1);
                    timeout_n  = 1'b1;
                end else if (hold_cnt < HC_W'(MAX_HOLD)) begin
                    hold_cnt_n = hold_cnt + HC_W'(1);
                end
            end
            default: begin
                state_n     = IDLE;
                gnt_n       = '0;
                gnt_valid_n = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any grant and rewinds the pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_id   <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            last_id   <= last_id_n;
            hold_cnt  <= hold_cnt_n;
            gnt       <= gnt_n;
            gnt_id    <= gnt_id_n;
            gnt_valid <= gnt_valid_n;
            timeout   <= timeout_n;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8 built around a behavioural reference model.
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int compared   = 0;
    int mismatched = 0;

    int m_owner = -1;
    int m_last  = 0;
    int m_hold  = 0;
    int m_to    = 0;

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Highest requester strictly below the last owner, else highest overall.
    function automatic int pick(input logic [7:0] r, input int last);
        for (int i = last - 1; i >= 0; i--) begin
            if (r[i]) return i;
        end
        for (int i = 7; i >= 0; i--) begin
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Advances the reference model by one clock edge.
    task automatic modelStep(input logic r_rst, input logic [7:0] r);
        logic [7:0] others;
        int         w;
        m_to = 0;
        if (r_rst) begin
            m_owner = -1;
            m_last  = 0;
            m_hold  = 0;
        end else if (m_owner < 0 || r[m_owner] == 1'b0) begin
            w = pick(r, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_hold  = 1;
            end else begin
                m_owner = -1;
            end
        end else begin
            others          = r;
            others[m_owner] = 1'b0;
            if (MAX_HOLD != 0 && m_hold == MAX_HOLD && others != 8'h00) begin
                w       = pick(others, m_last);
                m_owner = w;
                m_last  = w;
                m_hold  = 1;
                m_to    = 1;
            end else if (m_hold < MAX_HOLD) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    task automatic expectVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares every DUT output against the reference model.
    task automatic checkOutput(input string tag);
        logic [7:0] exp_gnt;
        exp_gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        expectVal({tag, "/gnt"}, {24'h0, gnt}, {24'h0, exp_gnt});
        expectVal({tag, "/gnt_valid"}, {31'h0, gnt_valid}, (m_owner >= 0) ? 32'd1 : 32'd0);
        expectVal({tag, "/timeout"}, {31'h0, timeout}, m_to);
        if (m_owner >= 0) begin
            expectVal({tag, "/gnt_id"}, {29'h0, gnt_id}, m_owner);
        end
    endtask

    // Drives one cycle of inputs, steps the model at the edge, then checks.
    task automatic applyStimulus(input string tag, input logic r_rst, input logic [7:0] r);
        rst = r_rst;
        req = r;
        @(posedge clk);
        modelStep(r_rst, r);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        int         order [9];
        logic [7:0] r;
        logic       rr;

        order = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

        $display("[TB] reset and idle");
        applyStimulus("reset", 1'b1, 8'h00);
        applyStimulus("reset", 1'b1, 8'h00);
        expectVal("reset/gnt_id", {29'h0, gnt_id}, 32'd0);
        for (int i = 0; i < 5; i++) applyStimulus("idle", 1'b0, 8'h00);

        $display("[TB] single request");
        applyStimulus("single", 1'b0, 8'h04);
        expectVal("single/gnt_const", {24'h0, gnt}, 32'h04);
        expectVal("single/id_const", {29'h0, gnt_id}, 32'd2);
        applyStimulus("single_drop", 1'b0, 8'h00);
        expectVal("single_drop/valid_const", {31'h0, gnt_valid}, 32'd0);

        $display("[TB] round-robin rotation");
        applyStimulus("rr_reset", 1'b1, 8'h00);
        applyStimulus("rr", 1'b0, 8'hFF);
        expectVal("rr/first", {29'h0, gnt_id}, order[0]);
        for (int i = 1; i < 9; i++) begin
            applyStimulus("rr", 1'b0, 8'hFF & ~(8'h01 << order[i-1]));
            expectVal("rr/order", {29'h0, gnt_id}, order[i]);
            expectVal("rr/no_gap", {31'h0, gnt_valid}, 32'd1);
        end

        $display("[TB] back-to-back handoff");
        applyStimulus("b2b_reset", 1'b1, 8'h00);
        applyStimulus("b2b", 1'b0, 8'h20);
        applyStimulus("b2b", 1'b0, 8'h29);
        expectVal("b2b/owner5", {29'h0, gnt_id}, 32'd5);
        applyStimulus("b2b", 1'b0, 8'h09);
        expectVal("b2b/to3", {29'h0, gnt_id}, 32'd3);
        applyStimulus("b2b", 1'b0, 8'h01);
        expectVal("b2b/to0", {29'h0, gnt_id}, 32'd0);
        applyStimulus("b2b", 1'b0, 8'h20);
        expectVal("b2b/to5", {29'h0, gnt_id}, 32'd5);

        $display("[TB] hold timeout");
        applyStimulus("to_reset", 1'b1, 8'h00);
        applyStimulus("to", 1'b0, 8'h82);
        expectVal("to/owner7", {29'h0, gnt_id}, 32'd7);
        for (int i = 0; i < 3; i++) applyStimulus("to_hold7", 1'b0, 8'h82);
        expectVal("to/still7", {29'h0, gnt_id}, 32'd7);
        applyStimulus("to", 1'b0, 8'h82);
        expectVal("to/revoke_id", {29'h0, gnt_id}, 32'd1);
        expectVal("to/pulse", {31'h0, timeout}, 32'd1);
        applyStimulus("to_hold1", 1'b0, 8'h82);
        expectVal("to/pulse_end", {31'h0, timeout}, 32'd0);
        for (int i = 0; i < 2; i++) applyStimulus("to_hold1", 1'b0, 8'h82);
        applyStimulus("to", 1'b0, 8'h82);
        expectVal("to/back7", {29'h0, gnt_id}, 32'd7);
        for (int i = 0; i < 50; i++) begin
            applyStimulus("to_sole", 1'b0, 8'h80);
            expectVal("to/sole_no_pulse", {31'h0, timeout}, 32'd0);
        end

        $display("[TB] reset mid-grant");
        applyStimulus("mid_reset", 1'b1, 8'h00);
        applyStimulus("mid", 1'b0, 8'h08);
        applyStimulus("mid", 1'b0, 8'h09);
        expectVal("mid/owner3", {29'h0, gnt_id}, 32'd3);
        applyStimulus("mid_rst", 1'b1, 8'h09);
        expectVal("mid/dropped", {24'h0, gnt}, 32'h00);
        applyStimulus("mid", 1'b0, 8'h09);
        expectVal("mid/regrant3", {29'h0, gnt_id}, 32'd3);

        $display("[TB] randomized traffic");
        r = 8'h00;
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = 8'($urandom);
            end else begin
                r = r ^ (8'h01 << $urandom_range(0, 7));
            end
            rr = ($urandom_range(0, 59) == 0);
            applyStimulus("random", rr, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
